// File: rtl/mmio_bus_arbiter_if.sv
// Requester-side and MMIO-side signals shared by mmio_bus_arbiter.
// slave: arbiter view; master: view of the requesters plus MMIO controller.
interface mmio_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_cs;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ-1:0]        req_rd;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wr_data;
  logic [N_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]       req_rd_data;
  logic [N_REQ-1:0]        grant;
  logic                    mmio_cs;
  logic                    mmio_wr;
  logic                    mmio_rd;
  logic [ADDR_W-1:0]       mmio_addr;
  logic [DATA_W-1:0]       mmio_wr_data;
  logic [DATA_W-1:0]       mmio_rd_data;

  modport slave (
    input  req_cs, req_wr, req_rd, req_addr, req_wr_data, mmio_rd_data,
    output req_ack, req_rd_data, grant,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

  modport master (
    output req_cs, req_wr, req_rd, req_addr, req_wr_data, mmio_rd_data,
    input  req_ack, req_rd_data, grant,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO bus between N_REQ requesters: one registered bus cycle per grant.
// Define MMIO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state   | meaning
// S_IDLE  | waiting for any req_cs; arbitrate and latch the winner's command
// S_ISSUE | mmio_cs high for this one cycle; capture read data
// S_ACK   | req_ack pulse to the owner; release grant
module mmio_bus_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mmio_bus_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic [N_REQ-1:0]    r_grant, w_grant_nxt;
  logic [N_REQ-1:0]    r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
  logic                r_cs, w_cs_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_rd, w_rd_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic [IDX_W-1:0]    w_win;
  logic [N_REQ-1:0]    w_one;

  assign w_one = {{(N_REQ-1){1'b0}}, 1'b1};

`ifdef MMIO_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (bus.req_cs[i]) w_win = IDX_W'(i);
    end
  end
`else
  // Scan downward so the candidate nearest to last_grant+1 is written last and wins.
  always_comb begin
    w_win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last) + k) % N_REQ;
      if (bus.req_cs[idx]) w_win = IDX_W'(idx);
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = r_ack;
    w_rd_data_nxt = r_rd_data;
    w_cs_nxt      = r_cs;
    w_wr_nxt      = r_wr;
    w_rd_nxt      = r_rd;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    case (r_state)
      S_IDLE: begin
        if (|bus.req_cs) begin
          w_grant_nxt   = w_one << w_win;
          w_cs_nxt      = 1'b1;
          w_wr_nxt      = bus.req_wr[w_win];
          w_rd_nxt      = bus.req_rd[w_win] & ~bus.req_wr[w_win];
          w_addr_nxt    = bus.req_addr[w_win*ADDR_W +: ADDR_W];
          w_wr_data_nxt = bus.req_wr_data[w_win*DATA_W +: DATA_W];
          w_last_nxt    = w_win;
          w_state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_data_nxt = r_rd ? bus.mmio_rd_data : '0;
        w_cs_nxt      = 1'b0;
        w_wr_nxt      = 1'b0;
        w_rd_nxt      = 1'b0;
        w_ack_nxt     = r_grant;
        w_state_nxt   = S_ACK;
      end
      S_ACK: begin
        w_ack_nxt   = '0;
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last    <= IDX_W'(N_REQ-1);
      r_grant   <= '0;
      r_ack     <= '0;
      r_rd_data <= '0;
      r_cs      <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_cs      <= w_cs_nxt;
      r_wr      <= w_wr_nxt;
      r_rd      <= w_rd_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.req_ack      = r_ack;
  assign bus.req_rd_data  = r_rd_data;
  assign bus.mmio_cs      = r_cs;
  assign bus.mmio_wr      = r_wr;
  assign bus.mmio_rd      = r_rd;
  assign bus.mmio_addr    = r_addr;
  assign bus.mmio_wr_data = r_wr_data;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter (3 requesters): directed scenarios plus random traffic
// against a transaction-level model that predicts issue/ack cycles by timestamp.
module tb_mmio_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  mmio_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: edge index of the winning decision (m_ti), ack follows at m_ti+1
  int              m_last, m_free, m_ti, m_g;
  logic            m_wr, m_rd;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wd, m_rdd;
  int              ack_log[$];
  logic [N-1:0]    pend;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] cs, input int last);
`ifdef MMIO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (cs[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (cs[j]) return j;
    end
`endif
    return 0;
  endfunction

  task automatic step();
    int e;
    logic [N-1:0] one;
    logic [N-1:0] g_exp;
    bit is_iss, is_ack;
    e   = cyc + 1;
    one = 1;
    if (!reset) begin
      m_last = N-1;
      m_free = e + 1;
      m_ti   = -10;
      m_rdd  = '0;
    end else begin
      if (e == m_ti + 1) m_rdd = m_rd ? bus.mmio_rd_data : '0;
      if (e >= m_free && |bus.req_cs) begin
        m_g    = pick(bus.req_cs, m_last);
        m_last = m_g;
        m_ti   = e;
        m_free = e + 3;
        m_wr   = bus.req_wr[m_g];
        m_rd   = bus.req_rd[m_g] & ~bus.req_wr[m_g];
        m_addr = bus.req_addr[m_g*AW +: AW];
        m_wd   = bus.req_wr_data[m_g*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
    cyc    = e;
    is_iss = (e == m_ti);
    is_ack = (e == m_ti + 1);
    g_exp  = (is_iss || is_ack) ? (one << m_g) : '0;
    chk_val("grant",   bus.grant,   g_exp);
    chk_val("ack",     bus.req_ack, is_ack ? (one << m_g) : '0);
    chk_val("mmio_cs", bus.mmio_cs, is_iss);
    chk_val("mmio_wr", bus.mmio_wr, is_iss ? m_wr : 1'b0);
    chk_val("mmio_rd", bus.mmio_rd, is_iss ? m_rd : 1'b0);
    if (is_iss) begin
      chk_val("mmio_addr", bus.mmio_addr,    m_addr);
      chk_val("mmio_wd",   bus.mmio_wr_data, m_wd);
    end
    chk_val("rd_data", bus.req_rd_data, m_rdd);
    for (int i = 0; i < N; i++) if (bus.req_ack[i]) ack_log.push_back(i);
  endtask

  task automatic set_req(input int i, input bit wr, input bit rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_cs[i]                = 1'b1;
    bus.req_wr[i]                = wr;
    bus.req_rd[i]                = rd;
    bus.req_addr[i*AW +: AW]     = a;
    bus.req_wr_data[i*DW +: DW]  = d;
  endtask

  task automatic clr_req();
    bus.req_cs = '0;
    bus.req_wr = '0;
    bus.req_rd = '0;
  endtask

  initial begin
    reset = 1'b0;
    clr_req();
    bus.req_addr     = '0;
    bus.req_wr_data  = '0;
    bus.mmio_rd_data = '0;
    pend   = '0;
    m_g    = 0;
    m_ti   = -10;
    m_free = 0;
    m_last = N-1;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    m_rdd  = '0;

    step();
    chk_val("rst_addr", bus.mmio_addr,    '0);
    chk_val("rst_wd",   bus.mmio_wr_data, '0);
    step();
    reset = 1'b1;
    step();

    // single read
    set_req(0, 1'b0, 1'b1, 21'h000A0, 32'h0);
    bus.mmio_rd_data = 32'h12345678;
    step();
    chk_val("rd1_cs",   bus.mmio_cs,   1'b1);
    chk_val("rd1_rd",   bus.mmio_rd,   1'b1);
    chk_val("rd1_addr", bus.mmio_addr, 21'h000A0);
    step();
    chk_val("rd1_ack",  bus.req_ack,     3'b001);
    chk_val("rd1_data", bus.req_rd_data, 32'h12345678);
    clr_req();
    step();
    chk_val("rd1_cs_off", bus.mmio_cs, 1'b0);

    // write with both strobes set
    set_req(1, 1'b1, 1'b1, 21'h01234, 32'hDEADBEEF);
    bus.mmio_rd_data = 32'hCAFEF00D;
    step();
    chk_val("wr_wr", bus.mmio_wr,      1'b1);
    chk_val("wr_rd", bus.mmio_rd,      1'b0);
    chk_val("wr_wd", bus.mmio_wr_data, 32'hDEADBEEF);
    step();
    chk_val("wr_ack",  bus.req_ack,     3'b010);
    chk_val("wr_data", bus.req_rd_data, 32'h0);
    clr_req();
    step();

    // contention between requesters 0 and 1
    set_req(0, 1'b0, 1'b1, 21'h00010, 32'h0);
    set_req(1, 1'b1, 1'b0, 21'h00020, 32'h00000055);
    for (int t = 0; t < 12; t++) begin
      step();
      if (t % 3 == 1) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
        chk_val("cont_ack", bus.req_ack, 3'b001);
`else
        chk_val("cont_ack", bus.req_ack, ((t / 3) % 2 == 0) ? 3'b001 : 3'b010);
`endif
      end
    end
`ifdef MMIO_ARB_FIXED_PRIO_EN
    bus.req_cs[0] = 1'b0;
    step();
    chk_val("cont_next", bus.grant, 3'b010);
`else
    step();
    chk_val("cont_next", bus.grant, 3'b001);
`endif
    step();
    clr_req();
    step();

    // reset during ISSUE
    set_req(0, 1'b0, 1'b1, 21'h00030, 32'h0);
    step();
    chk_val("mid_iss", bus.mmio_cs, 1'b1);
    reset = 1'b0;
    step();
    chk_val("mid_ack",   bus.req_ack, 3'b000);
    chk_val("mid_cs",    bus.mmio_cs, 1'b0);
    chk_val("mid_grant", bus.grant,   3'b000);
    reset = 1'b1;
    set_req(1, 1'b0, 1'b1, 21'h00031, 32'h0);
    step();
    chk_val("mid_first", bus.grant, 3'b001);
    step();
    clr_req();
    step();

    // wrap-around: requester 2 alone, then 0 and 1
    ack_log.delete();
    set_req(2, 1'b0, 1'b1, 21'h00040, 32'h0);
    step();
    step();
    clr_req();
    set_req(0, 1'b1, 1'b0, 21'h00041, 32'h11111111);
    set_req(1, 1'b0, 1'b0, 21'h00042, 32'h0);
    for (int t = 0; t < 7; t++) begin
      step();
      for (int i = 0; i < N; i++) if (bus.req_ack[i]) bus.req_cs[i] = 1'b0;
    end
    chk_val("wrap_n", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk_val("wrap_0", ack_log[0], 2);
      chk_val("wrap_1", ack_log[1], 0);
      chk_val("wrap_2", ack_log[2], 1);
    end
    clr_req();
    step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i]) begin
          pend[i]       = 1'b0;
          bus.req_cs[i] = 1'b0;
        end else if (pend[i] && bus.grant[i] && bus.mmio_cs && $urandom_range(7) == 0) begin
          bus.req_cs[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom), $urandom);
        end
      end
      bus.mmio_rd_data = $urandom;
      if ($urandom_range(150) == 0) begin
        reset = 1'b0;
        pend  = '0;
        clr_req();
      end else begin
        reset = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single FPro MMIO bus (cs/wr/rd/addr/wr_data/rd_data) between N_REQ requesters, e.g. the CPU and an autonomous sampler engine that polls the XADC and PWM slots.
- Each requester holds a request until it gets a one-cycle ack. The arbiter issues exactly one registered bus cycle per grant and returns captured read data.
- Sits between the requesters and the MMIO controller in the sampler subsystem.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..4)
- ADDR_W, 21, MMIO address width
- DATA_W, 32, MMIO data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_cs  in  N_REQ  per-requester request valid
- req_wr  in  N_REQ  per-requester write strobe
- req_rd  in  N_REQ  per-requester read strobe
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wr_data  in  N_REQ*DATA_W  packed write data, same packing
- req_ack  out  N_REQ  one-hot, one-cycle completion pulse
- req_rd_data  out  DATA_W  captured read data, shared by all requesters; valid while req_ack is high
- grant  out  N_REQ  one-hot owner of the current transaction; 0 when IDLE
- mmio_cs  out  1  bus chip select
- mmio_wr  out  1  bus write strobe
- mmio_rd  out  1  bus read strobe
- mmio_addr  out  ADDR_W  bus address
- mmio_wr_data  out  DATA_W  bus write data
- mmio_rd_data  in  DATA_W  bus read data (same-cycle response from the controller)

Behaviour:
- Clock and reset: all state changes on the rising edge of clk. Reset is sampled on clk only.
- Reset values:
  - state = IDLE
  - grant = 0, req_ack = 0, req_rd_data = 0
  - mmio_cs/wr/rd = 0, mmio_addr = 0, mmio_wr_data = 0
  - last_grant pointer = N_REQ-1, so requester 0 wins the first contest.
- Bus outputs: all mmio_* outputs are registered. mmio_cs is high for exactly one cycle per transaction, and never in IDLE or ACK.
- FSM, 3 states:
  - IDLE: if any req_cs bit is set, pick winner g by round-robin, scanning from (last_grant+1) mod N_REQ upward with wrap. Then:
    - register grant = 1<<g
    - mmio_cs = 1, mmio_addr = req_addr[g], mmio_wr_data = req_wr_data[g]
    - mmio_wr = req_wr[g]
    - mmio_rd = req_rd[g] & ~req_wr[g] (write wins if both set)
    - last_grant = g, go to ISSUE.
    - If no req_cs bit is set, stay in IDLE.
  - ISSUE: bus cycle is active. At the clock edge:
    - req_rd_data <= mmio_rd_data if mmio_rd, else 0
    - drop mmio_cs/wr/rd, set req_ack = grant, go to ACK.
  - ACK: req_ack[g] high for this one cycle. Next edge: req_ack = 0, grant = 0, go to IDLE.
- Latency and throughput: request seen in IDLE at cycle N gives bus cycle at N+1 and ack at N+2. One transaction per 3 cycles minimum. With continuous requests from all requesters, grants rotate strictly.
- Requester contract:
  - hold req_cs/rd/wr/addr/wr_data stable until ack
  - drop or change them the cycle after ack
  - changes made in ISSUE or ACK are ignored, since the transaction was latched in IDLE.
- Boundary cases:
  - req_cs with rd=wr=0 still produces an mmio_cs-only cycle and an ack, with req_rd_data = 0.
  - A requester deasserting req_cs after being granted does not abort; the ack is still issued.
  - last_grant wraps N_REQ-1 -> 0.
  - Reset low in any state returns to IDLE next edge with no ack and all bus strobes low; the in-flight transaction is lost.
  - req_rd_data holds its value until the next read transaction completes (or is zeroed by a non-read transaction).

Optional Feature:
- Macro: MMIO_ARB_FIXED_PRIO_EN
- When defined: IDLE arbitration is fixed priority, lowest index wins. last_grant is still maintained but not used for selection.
- When undefined: round-robin as described above.
- All timing, the FSM and the ack protocol are identical in both builds.

Test Plan:
- Single read: req_cs[0]=1, req_rd[0]=1, addr=0x000A0, mmio_rd_data=0x12345678. Required: mmio_cs/mmio_rd high exactly one cycle at N+1 with mmio_addr=0x000A0; req_ack=2'b01 at N+2; req_rd_data=0x12345678.
- Write with both strobes set: req1 with wr=rd=1, wr_data=0xDEADBEEF. Required: mmio_wr=1, mmio_rd=0, mmio_wr_data=0xDEADBEEF; ack=2'b10; req_rd_data=0.
- Contention: req0 and req1 held continuously for 4 transactions. Required: grant sequence 01,10,01,10, acks at cycles 2,5,8,11 after start.
- Fixed priority (macro defined): same stimulus. Required: req0 granted every transaction; req1 granted only after req0 drops.
- Reset mid-operation: drive reset=0 during ISSUE. Required: next cycle state IDLE, req_ack=0, mmio_cs=0, grant=0; the following contest is won by requester 0.
- Wrap-around with N_REQ=3: only req2 then req0 and req1 requesting. Required: order 2,0,1, one ack each, no duplicate acks.
